// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: memory op codes,
// arbiter states and port identifiers.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        RAM_IDLE  = 2'd0,
        RAM_GET   = 2'd1,
        RAM_SET   = 2'd2,
        RAM_RESET = 2'd3
    } ram_op_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // A request only counts when it carries a real operation.
    function automatic logic is_valid_req(input logic req, input logic [1:0] op);
        return req && (op != RAM_IDLE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin selector: on a tie the port that did not win last
// time is chosen.
module rr_pick
    import ram_arbiter_pkg::*;
(
    input  logic  i_valid_a,
    input  logic  i_valid_b,
    input  port_e i_last,
    output port_e o_sel,
    output logic  o_any
);

    always_comb begin
        // NOTE: o_sel gets a default before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_sel = PORT_A;
        if (i_valid_a && i_valid_b) begin
            o_sel = (i_last == PORT_A) ? PORT_B : PORT_A;
        end else if (i_valid_b) begin
            o_sel = PORT_B;
        end
    end

    assign o_any = i_valid_a || i_valid_b;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one memory between port A and port B: round-robin grant, memory
// op/done handshake on the winner's behalf, done pulse and watchdog abort.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic [1:0]        a_op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    input  logic              b_req,
    input  logic [1:0]        b_op,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_e        r_state;
    port_e             r_last;
    port_e             r_win;
    logic [WD_W-1:0]   r_wd;
    ram_op_e           r_mem_op;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_a_gnt;
    logic              r_b_gnt;
    logic              r_a_done;
    logic              r_b_done;
    logic              r_err;

    logic              w_valid_a;
    logic              w_valid_b;
    port_e             w_sel;
    logic              w_any;
    logic [1:0]        w_sel_op;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_valid_a = is_valid_req(a_req, a_op);
    assign w_valid_b = is_valid_req(b_req, b_op);

    rr_pick u_rr_pick (
        .i_valid_a (w_valid_a),
        .i_valid_b (w_valid_b),
        .i_last    (r_last),
        .o_sel     (w_sel),
        .o_any     (w_any)
    );

    assign w_sel_op    = (w_sel == PORT_B) ? b_op    : a_op;
    assign w_sel_addr  = (w_sel == PORT_B) ? b_addr  : a_addr;
    assign w_sel_wdata = (w_sel == PORT_B) ? b_wdata : a_wdata;

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking writes would let later statements see half-updated state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ARB;
            r_last      <= PORT_B;
            r_win       <= PORT_A;
            r_wd        <= '0;
            r_mem_op    <= RAM_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_win       <= w_sel;
                        r_a_gnt     <= (w_sel == PORT_A);
                        r_b_gnt     <= (w_sel == PORT_B);
                        r_mem_op    <= ram_op_e'(w_sel_op);
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_wd        <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    r_wd <= r_wd + 1'b1;
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (mem_done || (r_wd == WD_LAST)) begin
                        if (mem_done && (r_mem_op == RAM_GET)) begin
                            r_rdata <= mem_rdata;
                        end
                        r_err    <= !mem_done;
                        r_a_done <= (r_win == PORT_A);
                        r_b_done <= (r_win == PORT_B);
                        r_a_gnt  <= 1'b0;
                        r_b_gnt  <= 1'b0;
                        r_mem_op <= RAM_IDLE;
                        r_last   <= r_win;
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_a_done <= 1'b0;
                    r_b_done <= 1'b0;
                    r_err    <= 1'b0;
                    if (!mem_done) begin
                        r_state <= ARB;
                    end
                end
                default: begin
                    r_state <= ARB;
                end
            endcase
        end
    end

    assign a_gnt     = r_a_gnt;
    assign b_gnt     = r_b_gnt;
    assign a_done    = r_a_done;
    assign b_done    = r_b_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_op    = r_mem_op;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed and random transactions against a memory
// model, with expectations from a transaction-level reference.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic [1:0]    a_op = 2'd0, b_op = 2'd0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_done, b_gnt, b_done, err;
    logic [DW-1:0] rdata, mem_wdata;
    logic [1:0]    mem_op;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Memory environment
    logic [DW-1:0] mem_arr [16];
    bit            mem_inited = 1'b0;
    int            mem_lat = 2;
    bit            hang = 1'b0;
    int            mcnt = 0;

    // Reference state
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ref_rdata = '0;
    bit            ref_last = 1'b1;

    // Monitors
    int both_gnt = 0, both_done = 0;
    int a_gnt_cnt = 0, b_gnt_cnt = 0, a_done_cnt = 0, b_done_cnt = 0;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_req     (a_req),
        .a_op      (a_op),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_done    (a_done),
        .b_req     (b_req),
        .b_op      (b_op),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_done    (b_done),
        .rdata     (rdata),
        .err       (err),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory completes mem_lat cycles after it first sees an op; done held until op goes IDLE.
    always @(posedge clk) begin
        if (!mem_inited) begin
            foreach (mem_arr[i]) mem_arr[i] <= '0;
            mem_inited <= 1'b1;
        end else if (mem_op == 2'd0) begin
            mem_done <= 1'b0;
            mcnt     <= 0;
        end else if (!mem_done && hang) begin
            mem_rdata <= DW'($urandom);
        end else if (!mem_done) begin
            if (mcnt >= mem_lat - 1) begin
                case (mem_op)
                    2'd1:    mem_rdata <= mem_arr[mem_addr];
                    2'd2:    begin mem_arr[mem_addr] <= mem_wdata; mem_rdata <= DW'($urandom); end
                    default: begin mem_arr[mem_addr] <= '0;        mem_rdata <= DW'($urandom); end
                endcase
                mem_done <= 1'b1;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (a_gnt && b_gnt)   both_gnt++;
        if (a_done && b_done) both_done++;
        if (a_gnt)  a_gnt_cnt++;
        if (b_gnt)  b_gnt_cnt++;
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        ref_last  = 1'b1;
        ref_rdata = '0;
    endtask

    // Present up to two requests at once and follow them to completion.
    task automatic run_round(input string tag,
                             input bit ra, input logic [1:0] opa, input logic [3:0] ada, input logic [15:0] wda,
                             input bit rb, input logic [1:0] opb, input logic [3:0] adb, input logic [15:0] wdb);
        logic [1:0]  op_of [2];
        logic [3:0]  ad_of [2];
        logic [15:0] wd_of [2];
        logic [15:0] exp_rd;
        bit va, vb, first, p;
        int n_exp, got, start;
        op_of[0] = opa; ad_of[0] = ada; wd_of[0] = wda;
        op_of[1] = opb; ad_of[1] = adb; wd_of[1] = wdb;
        va    = ra && (opa != 2'd0);
        vb    = rb && (opb != 2'd0);
        n_exp = int'(va) + int'(vb);
        first = (va && vb) ? !ref_last : !va;
        a_req = ra; a_op = opa; a_addr = ada; a_wdata = wda;
        b_req = rb; b_op = opb; b_addr = adb; b_wdata = wdb;
        start = cyc;
        got   = 0;
        tick();
        if (n_exp > 0) begin
            check({tag, "_issue"}, 32'({mem_op, mem_addr, mem_wdata, a_gnt, b_gnt}),
                  32'({op_of[first], ad_of[first], wd_of[first], !first, first}));
        end
        for (int t = 0; t < 400 && got < n_exp; t++) begin
            tick();
            if (a_done || b_done) begin
                p = b_done;
                check({tag, "_order"}, 32'(p), 32'((got == 0) ? first : !first));
                if (got == 0) check({tag, "_latency"}, 32'(cyc - start), 32'(mem_lat + 2));
                exp_rd = (op_of[p] == 2'd1) ? ref_mem[ad_of[p]] : ref_rdata;
                check({tag, "_err_rdata"}, 32'({err, rdata}), 32'({1'b0, exp_rd}));
                ref_rdata = exp_rd;
                if (op_of[p] == 2'd2) ref_mem[ad_of[p]] = wd_of[p];
                if (op_of[p] == 2'd3) ref_mem[ad_of[p]] = '0;
                ref_last = p;
                if (p) b_req = 1'b0; else a_req = 1'b0;
                got++;
            end
        end
        check({tag, "_count"}, 32'(got), 32'(n_exp));
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int snap_a, snap_b, n, k, idle_bad;
        logic [3:0]  ada, adb;
        logic [15:0] hold_rd;
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Reset values
        tick();
        check("reset_mem", 32'({mem_op, mem_addr, mem_wdata}), 32'(0));
        check("reset_ctl", 32'({a_gnt, b_gnt, a_done, b_done, err, rdata}), 32'(0));
        reset_n = 1'b1;
        repeat (2) tick();

        // A alone: SET addr 3
        snap_a = a_done_cnt; snap_b = b_gnt_cnt;
        mem_lat = 2;
        run_round("a_set", 1'b1, 2'd2, 4'd3, 16'h00A5, 1'b0, 2'd0, 4'd0, 16'h0);
        check("a_set_done_pulses", 32'(a_done_cnt - snap_a), 32'(1));
        check("a_set_no_b_gnt", 32'(b_gnt_cnt - snap_b), 32'(0));
        check("a_set_mem3", 32'(mem_arr[3]), 32'(16'h00A5));

        // B reads it back
        snap_a = a_done_cnt;
        run_round("b_get", 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 2'd1, 4'd3, 16'h0);
        check("b_get_no_a_done", 32'(a_done_cnt - snap_a), 32'(0));

        // Continuous contention from reset
        do_reset();
        ada = 4'($urandom); adb = 4'($urandom);
        a_req = 1'b1; a_op = 2'd1; a_addr = ada;
        b_req = 1'b1; b_op = 2'd1; b_addr = adb;
        k = 0;
        for (int t = 0; t < 300 && k < 6; t++) begin
            tick();
            if (a_done || b_done) begin
                check("alt_order", 32'(b_done), 32'(k % 2));
                check("alt_rdata", 32'(rdata), 32'(ref_mem[b_done ? adb : ada]));
                ref_rdata = rdata;
                k++;
            end
        end
        check("alt_count", 32'(k), 32'(6));
        ref_last = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) tick();

        // Hung memory: watchdog abort
        hang = 1'b1;
        hold_rd = ref_rdata;
        a_req = 1'b1; a_op = 2'd1; a_addr = 4'd5;
        n = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (a_done) break;
            if (a_gnt) n++;
        end
        check("hang_busy_cycles", 32'(n), 32'(TO));
        check("hang_done_err", 32'({a_done, err, rdata}), 32'({1'b1, 1'b1, hold_rd}));
        a_req = 1'b0;
        tick();
        check("hang_after", 32'({a_done, err, mem_op}), 32'(0));
        hang = 1'b0;
        ref_last = 1'b0;
        repeat (3) tick();

        // Done in the final watchdog cycle is success
        mem_lat = TO - 1;
        run_round("edge_timeout", 1'b1, 2'd1, 4'd3, 16'h0, 1'b0, 2'd0, 4'd0, 16'h0);
        mem_lat = 2;

        // IDLE-op request never granted, B served meanwhile
        snap_a = a_gnt_cnt;
        a_req = 1'b1; a_op = 2'd0;
        idle_bad = 0;
        repeat (20) begin
            tick();
            if (mem_op != 2'd0 || a_gnt) idle_bad++;
        end
        check("idle_op_ignored", 32'(idle_bad), 32'(0));
        run_round("idle_b", 1'b1, 2'd0, 4'd1, 16'h0, 1'b1, 2'd1, 4'd3, 16'h0);
        check("idle_no_a_gnt", 32'(a_gnt_cnt - snap_a), 32'(0));

        // Reset in the second BUSY cycle of a SET
        a_req = 1'b1; a_op = 2'd2; a_addr = 4'd7; a_wdata = 16'h1234;
        tick();
        check("rst_busy0", 32'({a_gnt, mem_op}), 32'({1'b1, 2'd2}));
        tick();
        b_req = 1'b1; b_op = 2'd1; b_addr = 4'd7;
        reset_n = 1'b0;
        #1;
        check("rst_async", 32'({mem_op, a_gnt, b_gnt, a_done, b_done, err}), 32'(0));
        tick();
        reset_n = 1'b1;
        ref_last = 1'b1;
        ref_rdata = '0;
        run_round("rst_regrant", 1'b1, 2'd2, 4'd7, 16'h1234, 1'b1, 2'd1, 4'd7, 16'h0);

        // Random traffic
        for (int r = 0; r < 24; r++) begin
            mem_lat = int'($urandom_range(1, 4));
            run_round("rand", 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                      1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
        end

        check("never_both_gnt", 32'(both_gnt), 32'(0));
        check("never_both_done", 32'(both_done), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 16x16 `memory` instance between two requesters: port A (CPU sequencer) and port B (LCD refresh / display readback).
- Arbitrates round-robin and sequences the memory operation/done handshake on the winner's behalf.
- Returns read data plus a one-cycle completion pulse to the winner.
- Guards against a hung memory with a watchdog timeout.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 4, memory address width.
- TIMEOUT, 64, maximum cycles to wait for mem_done before aborting; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- a_req  in  1  port A request; held high until a_done.
- a_op  in  2  port A operation: 0 IDLE, 1 GET, 2 SET, 3 RESET.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A currently owns the memory.
- a_done  out  1  one-cycle completion pulse to port A.
- b_req, b_op, b_addr, b_wdata, b_gnt, b_done: same as the port A signals, for port B.
- rdata  out  DATA_W  data captured on GET completion; valid in the done cycle, held until the next completion.
- err  out  1  one-cycle pulse, coincident with done, when the access timed out.
- mem_op  out  2  operation to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data.
- mem_done  in  1  memory completion level.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state=ARB; last=B, so A wins the first tie.
  - mem_op=IDLE; mem_addr=0; mem_wdata=0.
  - a_gnt=b_gnt=0; a_done=b_done=0; err=0; rdata=0; watchdog=0.
- Valid request: reqX high and opX != IDLE. A request with op IDLE is ignored and never granted.
- All outputs are registered. Memory protocol: mem_op is held non-IDLE until mem_done is seen high. The arbiter then drives IDLE and waits for mem_done low before issuing the next operation.
- State ARB:
  - If exactly one port has a valid request, grant it.
  - If both do, grant the port that is not `last`.
  - On grant, register gntX=1, mem_op=opX, mem_addr=addrX, mem_wdata=wdataX, watchdog=0, then go to BUSY.
  - Latency: request sampled in cycle n, mem_op valid in cycle n+1.
- State BUSY:
  - Inputs of the winning port are not resampled.
  - watchdog increments every cycle.
  - If mem_done=1: rdata<=mem_rdata when op was GET (otherwise unchanged); doneX<=1; mem_op<=IDLE; last<=winner; go to DRAIN.
  - Else if watchdog==TIMEOUT-1: same exit with rdata unchanged and err<=1.
- State DRAIN:
  - doneX and err are cleared after one cycle.
  - gntX is dropped on entry to DRAIN, in the same cycle as doneX.
  - Stay while mem_done=1; go to ARB when mem_done=0.
  - Minimum request-to-done latency: n+1 issue, done observed n+2, pulse n+3.
- Requester rules:
  - reqX may drop in the cycle after doneX; a still-high reqX is a new request.
  - Dropping reqX during BUSY does not cancel the operation; doneX still pulses.
- Fairness: under continuous requests from both ports, grants strictly alternate A,B,A,B. No port waits more than one other transaction.
- Simultaneous events:
  - mem_done and timeout in the same cycle: treated as success, err=0.
  - A new request arriving during BUSY/DRAIN waits in ARB.
- Reset mid-operation: everything returns to reset values immediately, so mem_op=IDLE. Memory contents are not this block's concern.
- Never both gnt high; at most one done high per cycle.

Decomposition:
- Shared package/include:
  - memory op codes: RAM_IDLE=0, RAM_GET=1, RAM_SET=2, RAM_RESET=3.
  - arbiter state encodings ARB/BUSY/DRAIN.
  - port-select constants PORT_A/PORT_B.
- Sub-module rr_pick: pure round-robin selector taking valid_a, valid_b, last, and giving sel and any. Everything else lives in ram_arbiter.

Test Plan:
- A alone, SET addr 3 wdata 0x00A5, memory model done after 2 cycles -> mem_op=2, mem_addr=3 one cycle after req. a_done pulses once. Memory addr 3 = 0x00A5. b_gnt never high.
- B GET addr 3 after the previous write -> b_done pulse with rdata=0x00A5, err=0, a_done stays 0.
- A and B both request GET continuously from reset, 6 transactions -> grant order A,B,A,B,A,B. a_done and b_done never in the same cycle.
- Memory model never asserts done, TIMEOUT=64 -> exactly 64 cycles in BUSY, then a_done=1 and err=1 for one cycle. rdata unchanged. mem_op returns to 0.
- a_req with a_op=0 held 20 cycles -> no grant, mem_op stays 0. b_req GET issued meanwhile is served normally.
- reset_n pulled low in the second BUSY cycle of a SET -> mem_op=0, gnt=0, done=0 asynchronously. After release, a held A request is re-granted first.
